// File: rtl/uart_bus_master.sv
// UART (8N1) command receiver issuing single 8-bit Wishbone cycles: 'W' adr dat / 'R' adr.
// Optional ack watchdog is built when UART_BUS_TIMEOUT_EN is defined.
module uart_bus_master #(
  parameter int CLKS_PER_BIT = 16,
  parameter int ACK_TIMEOUT  = 255
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rxd,
  output logic       stb_o,
  output logic       we_o,
  output logic [7:0] adr_o,
  output logic [7:0] dat_o,
  input  logic       ack_i,
  output logic       busy_o,
  output logic       frame_err_o,
  output logic       overrun_o,
  output logic       timeout_o
);
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    RX_IDLE = 2'd0, RX_START = 2'd1, RX_DATA = 2'd2, RX_STOP = 2'd3
  } rx_state_t;
  typedef enum logic [2:0] {
    P_HDR = 3'd0, P_WADR = 3'd1, P_WDAT = 3'd2, P_RADR = 3'd3, P_BUS = 3'd4
  } p_state_t;

  logic             rxd_meta_r, rxd_sync_r, rxd_prev_r;
  rx_state_t        rx_state_r, rx_state_n;
  logic [CNT_W-1:0] cnt_r, cnt_n;
  logic [2:0]       bit_idx_r, bit_idx_n;
  logic [7:0]       shift_r, shift_n;
  logic             byte_valid_r, byte_valid_n;
  logic             frame_err_r, frame_err_n;
  p_state_t         p_state_r, p_state_n;
  logic             stb_r, we_r, overrun_r;
  logic [7:0]       adr_r, dat_r;
  logic             to_hit_s;

  // rxd synchronizer plus one history flop for falling-edge detection
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rxd_meta_r <= 1'b1;
      rxd_sync_r <= 1'b1;
      rxd_prev_r <= 1'b1;
    end else begin
      rxd_meta_r <= rxd;
      rxd_sync_r <= rxd_meta_r;
      rxd_prev_r <= rxd_sync_r;
    end
  end

  // Receiver next-state: mid-bit sampling from the detected start edge
  always_comb begin
    rx_state_n   = rx_state_r;
    cnt_n        = cnt_r;
    bit_idx_n    = bit_idx_r;
    shift_n      = shift_r;
    byte_valid_n = 1'b0;
    frame_err_n  = 1'b0;
    case (rx_state_r)
      RX_IDLE: begin
        cnt_n     = CNT_ZERO;
        bit_idx_n = 3'd0;
        if (rxd_prev_r && !rxd_sync_r) rx_state_n = RX_START;
        else                           rx_state_n = RX_IDLE;
      end
      RX_START: begin
        if (cnt_r == HALF_LAST) begin
          cnt_n = CNT_ZERO;
          if (!rxd_sync_r) rx_state_n = RX_DATA;
          else             rx_state_n = RX_IDLE;
        end else begin
          cnt_n = cnt_r + CNT_ONE;
        end
      end
      RX_DATA: begin
        if (cnt_r == BIT_LAST) begin
          cnt_n     = CNT_ZERO;
          shift_n   = {rxd_sync_r, shift_r[7:1]};
          bit_idx_n = bit_idx_r + 3'd1;
          if (bit_idx_r == 3'd7) rx_state_n = RX_STOP;
          else                   rx_state_n = RX_DATA;
        end else begin
          cnt_n = cnt_r + CNT_ONE;
        end
      end
      RX_STOP: begin
        if (cnt_r == BIT_LAST) begin
          cnt_n      = CNT_ZERO;
          rx_state_n = RX_IDLE;
          if (rxd_sync_r) byte_valid_n = 1'b1;
          else            frame_err_n  = 1'b1;
        end else begin
          cnt_n = cnt_r + CNT_ONE;
        end
      end
      default: rx_state_n = RX_IDLE;
    endcase
  end

  // Receiver registers
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rx_state_r   <= RX_IDLE;
      cnt_r        <= CNT_ZERO;
      bit_idx_r    <= 3'd0;
      shift_r      <= 8'h00;
      byte_valid_r <= 1'b0;
      frame_err_r  <= 1'b0;
    end else begin
      rx_state_r   <= rx_state_n;
      cnt_r        <= cnt_n;
      bit_idx_r    <= bit_idx_n;
      shift_r      <= shift_n;
      byte_valid_r <= byte_valid_n;
      frame_err_r  <= frame_err_n;
    end
  end

  // Parser next-state; a framing error only restarts a frame still being assembled
  always_comb begin
    p_state_n = p_state_r;
    case (p_state_r)
      P_HDR: begin
        if (byte_valid_r && shift_r == 8'h57)      p_state_n = P_WADR;
        else if (byte_valid_r && shift_r == 8'h52) p_state_n = P_RADR;
        else                                       p_state_n = P_HDR;
      end
      P_WADR: begin
        if (frame_err_r)       p_state_n = P_HDR;
        else if (byte_valid_r) p_state_n = P_WDAT;
        else                   p_state_n = P_WADR;
      end
      P_WDAT: begin
        if (frame_err_r)       p_state_n = P_HDR;
        else if (byte_valid_r) p_state_n = P_BUS;
        else                   p_state_n = P_WDAT;
      end
      P_RADR: begin
        if (frame_err_r)       p_state_n = P_HDR;
        else if (byte_valid_r) p_state_n = P_BUS;
        else                   p_state_n = P_RADR;
      end
      P_BUS: begin
        if (ack_i || to_hit_s) p_state_n = P_HDR;
        else                   p_state_n = P_BUS;
      end
      default: p_state_n = P_HDR;
    endcase
  end

  // Parser state and bus-side output registers
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      p_state_r <= P_HDR;
      stb_r     <= 1'b0;
      we_r      <= 1'b0;
      adr_r     <= 8'h00;
      dat_r     <= 8'h00;
      overrun_r <= 1'b0;
    end else begin
      p_state_r <= p_state_n;
      stb_r     <= (p_state_n == P_BUS);
      overrun_r <= byte_valid_r && (p_state_r == P_BUS);
      case (p_state_r)
        P_WADR: if (byte_valid_r) adr_r <= shift_r;
        P_WDAT: if (byte_valid_r) begin
          dat_r <= shift_r;
          we_r  <= 1'b1;
        end
        P_RADR: if (byte_valid_r) begin
          adr_r <= shift_r;
          we_r  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

`ifdef UART_BUS_TIMEOUT_EN
  localparam int TO_W = $clog2(ACK_TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_ZERO = TO_W'(0);
  localparam logic [TO_W-1:0] TO_ONE  = TO_W'(1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(ACK_TIMEOUT - 1);
  logic [TO_W-1:0] to_cnt_r;
  logic            timeout_r;

  assign to_hit_s = (p_state_r == P_BUS) && (to_cnt_r == TO_LAST);

  // Ack watchdog counts strobe cycles; an ack on the terminal cycle suppresses the abort
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      to_cnt_r  <= TO_ZERO;
      timeout_r <= 1'b0;
    end else begin
      timeout_r <= to_hit_s && !ack_i;
      if (p_state_r == P_BUS && !ack_i && !to_hit_s) to_cnt_r <= to_cnt_r + TO_ONE;
      else                                            to_cnt_r <= TO_ZERO;
    end
  end
  assign timeout_o = timeout_r;
`else
  logic unused_ack_timeout_s;
  assign unused_ack_timeout_s = (ACK_TIMEOUT > 0);
  assign to_hit_s  = 1'b0;
  assign timeout_o = 1'b0;
`endif

  assign stb_o       = stb_r;
  assign busy_o      = stb_r;
  assign we_o        = we_r;
  assign adr_o       = adr_r;
  assign dat_o       = dat_r;
  assign frame_err_o = frame_err_r;
  assign overrun_o   = overrun_r;
endmodule

// File: tb/tb_uart_bus_master.sv
// Self-checking bench for uart_bus_master: directed scenarios plus randomized commands
// scored against a byte-stream command model; timeout scenario depends on UART_BUS_TIMEOUT_EN.
module tb_uart_bus_master;
  localparam int CPB = 4;
  localparam int TO  = 8;

  logic       clk = 1'b0;
  logic       rst_i, rxd, ack_i;
  logic       stb_o, we_o, busy_o, frame_err_o, overrun_o, timeout_o;
  logic [7:0] adr_o, dat_o;

  int checks = 0, errors = 0;
  int ferr_cnt = 0, ovr_cnt = 0, to_cnt = 0;
  int exp_ferr = 0, exp_ovr = 0;
  int hi_len = 0, last_len = 0;
  logic        prev_stb = 1'b0, prev_ack_stb = 1'b0;
  logic [16:0] hold_val = 17'h0;
  logic [16:0] obs_q[$];
  logic [16:0] exp_q[$];
  logic [7:0]  pend[$];
  logic [7:0]  last_dat = 8'h00;
  logic        ack_en = 1'b0, stray_en = 1'b0;
  int          ack_delay = 0;

  uart_bus_master #(.CLKS_PER_BIT(CPB), .ACK_TIMEOUT(TO)) dut (
    .clk_i(clk), .rst_i(rst_i), .rxd(rxd), .stb_o(stb_o), .we_o(we_o),
    .adr_o(adr_o), .dat_o(dat_o), .ack_i(ack_i), .busy_o(busy_o),
    .frame_err_o(frame_err_o), .overrun_o(overrun_o), .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Command model: complete frames become expected bus transactions
  task automatic model_byte(input logic [7:0] b, input logic stop_ok, input logic bus_busy);
    if (!stop_ok) begin
      exp_ferr++;
      if (!bus_busy) pend.delete();
    end else if (bus_busy) begin
      exp_ovr++;
    end else begin
      pend.push_back(b);
      if (pend[0] != 8'h57 && pend[0] != 8'h52) pend.delete();
      else if (pend[0] == 8'h52 && pend.size() == 2) begin
        exp_q.push_back({1'b0, pend[1], last_dat});
        pend.delete();
      end else if (pend[0] == 8'h57 && pend.size() == 3) begin
        last_dat = pend[2];
        exp_q.push_back({1'b1, pend[1], pend[2]});
        pend.delete();
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    logic [9:0] frame;
    frame = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1 rxd = frame[i];
      repeat (CPB - 1) @(posedge clk);
    end
    @(posedge clk); #1 rxd = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic send(input logic [7:0] b, input logic stop_ok, input logic bus_busy);
    model_byte(b, stop_ok, bus_busy);
    send_byte(b, stop_ok);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    repeat (4) @(negedge clk);
    while (stb_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("idle_wait", {31'd0, stb_o}, 32'd0);
  endtask

  task automatic wait_stb();
    int n;
    n = 0;
    while (!stb_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("stb_wait", {31'd0, stb_o}, 32'd1);
  endtask

  // Ack responder: delayed single-cycle ack, or stray acks while no cycle is open
  initial begin : ack_responder
    int hi;
    hi = 0;
    ack_i = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (ack_i) begin
        ack_i = 1'b0;
        hi = 0;
      end else if (stb_o && ack_en) begin
        hi++;
        if (hi > ack_delay) ack_i = 1'b1;
      end else if (!stb_o && stray_en) begin
        ack_i = 1'b1;
        hi = 0;
      end else begin
        hi = 0;
      end
    end
  end

  // Bus monitor: records cycles, checks hold/termination, counts pulses
  always @(negedge clk) begin
    if (prev_ack_stb) check("stb_fall_after_ack", {31'd0, stb_o}, 32'd0);
    if (stb_o && !prev_stb) begin
      obs_q.push_back({we_o, adr_o, dat_o});
      hold_val = {we_o, adr_o, dat_o};
      hi_len = 1;
    end else if (stb_o && prev_stb) begin
      hi_len++;
      check("hold", {15'd0, we_o, adr_o, dat_o}, {15'd0, hold_val});
    end else if (!stb_o && prev_stb) begin
      last_len = hi_len;
    end
    if (frame_err_o) ferr_cnt++;
    if (overrun_o) ovr_cnt++;
    if (timeout_o) to_cnt++;
    prev_ack_stb = stb_o && ack_i;
    prev_stb = stb_o;
  end

  initial begin : main
    int kind;
    logic [7:0] ra, rd, rg;
    rxd = 1'b1;
    rst_i = 1'b1;
    #1 rst_i = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_i = 1'b1;
    @(negedge clk);
    check("rst_stb", {31'd0, stb_o}, 32'd0);
    check("rst_busy", {31'd0, busy_o}, 32'd0);
    check("rst_we", {31'd0, we_o}, 32'd0);
    check("rst_adr", {24'd0, adr_o}, 32'd0);
    check("rst_dat", {24'd0, dat_o}, 32'd0);
    check("rst_pulses", {29'd0, frame_err_o, overrun_o, timeout_o}, 32'd0);

    // Write with delayed ack
    ack_en = 1'b1; ack_delay = 2;
    send(8'h57, 1'b1, 1'b0); send(8'h21, 1'b1, 1'b0); send(8'hA5, 1'b1, 1'b0);
    wait_idle();

    // Read held until ack
    ack_en = 1'b0;
    send(8'h52, 1'b1, 1'b0); send(8'h93, 1'b1, 1'b0);
    repeat (20) @(negedge clk);
    check("read_hold_stb", {31'd0, stb_o}, 32'd1);
    check("read_hold_busy", {31'd0, busy_o}, 32'd1);
    check("read_we", {31'd0, we_o}, 32'd0);
    check("read_adr", {24'd0, adr_o}, 32'h93);
    ack_en = 1'b1; ack_delay = 0;
    wait_idle();
    check("idle_busy", {31'd0, busy_o}, 32'd0);

    // Noise: one-cycle glitch, junk header, then a valid write
    @(posedge clk); #1 rxd = 1'b0;
    @(posedge clk); #1 rxd = 1'b1;
    repeat (10) @(posedge clk);
    send(8'h00, 1'b1, 1'b0);
    send(8'h57, 1'b1, 1'b0); send(8'h3C, 1'b1, 1'b0); send(8'h5A, 1'b1, 1'b0);
    wait_idle();
    check("noise_txns", obs_q.size(), exp_q.size());

    // Framing error on header, orphan payload ignored
    send(8'h57, 1'b0, 1'b0); send(8'h21, 1'b1, 1'b0); send(8'hA5, 1'b1, 1'b0);
    wait_idle();
    check("frame_err_cnt", ferr_cnt, exp_ferr);
    check("frame_txns", obs_q.size(), exp_q.size());

    // Stray acks while no cycle is open are ignored
    stray_en = 1'b1;
    send(8'h57, 1'b1, 1'b0); send(8'h44, 1'b1, 1'b0);
    stray_en = 1'b0;
    repeat (3) @(posedge clk);
    send(8'h66, 1'b1, 1'b0);
    wait_idle();

    // Overrun during an outstanding read
    ack_en = 1'b0;
    send(8'h52, 1'b1, 1'b0); send(8'h0F, 1'b1, 1'b0);
    wait_stb();
    send(8'h52, 1'b1, 1'b1);
    repeat (3) @(negedge clk);
    check("overrun_cnt", ovr_cnt, exp_ovr);
    check("overrun_stb_held", {31'd0, stb_o}, 32'd1);
    ack_en = 1'b1;
    wait_idle();

    // Randomized commands
    for (int k = 0; k < 12; k++) begin
      kind = int'($urandom_range(0, 2));
      ra = 8'($urandom);
      rd = 8'($urandom);
      rg = 8'($urandom);
      ack_delay = int'($urandom_range(0, 3));
      if (kind == 0) begin
        send(8'h57, 1'b1, 1'b0); send(ra, 1'b1, 1'b0); send(rd, 1'b1, 1'b0);
      end else if (kind == 1) begin
        send(8'h52, 1'b1, 1'b0); send(ra, 1'b1, 1'b0);
      end else begin
        if (rg == 8'h57 || rg == 8'h52) rg = 8'h00;
        send(rg, 1'b1, 1'b0);
      end
      wait_idle();
    end

    // Timeout behaviour, then reset in the middle of a cycle
    ack_en = 1'b0;
    send(8'h52, 1'b1, 1'b0); send(8'h77, 1'b1, 1'b0);
`ifdef UART_BUS_TIMEOUT_EN
    wait_idle();
    check("timeout_len", last_len, TO);
    check("timeout_cnt", to_cnt, 1);
    send(8'h52, 1'b1, 1'b0); send(8'h78, 1'b1, 1'b0);
    wait_stb();
`else
    repeat (40) @(negedge clk);
    check("no_timeout_stb", {31'd0, stb_o}, 32'd1);
    check("no_timeout_cnt", to_cnt, 0);
`endif
    @(posedge clk); #3 rst_i = 1'b0;
    #1;
    check("rst_async_stb", {31'd0, stb_o}, 32'd0);
    check("rst_async_busy", {31'd0, busy_o}, 32'd0);
    check("rst_async_adr", {24'd0, adr_o}, 32'd0);
    pend.delete();
    last_dat = 8'h00;
    @(posedge clk); #1 rst_i = 1'b1;

    // Recovery write after reset
    ack_en = 1'b1; ack_delay = 1;
    send(8'h57, 1'b1, 1'b0); send(8'h12, 1'b1, 1'b0); send(8'h34, 1'b1, 1'b0);
    wait_idle();

    check("txn_count", obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      check("txn", {15'd0, obs_q[i]}, {15'd0, exp_q[i]});
    check("final_ferr", ferr_cnt, exp_ferr);
    check("final_ovr", ovr_cnt, exp_ovr);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_bus_master.md
# uart_bus_master

Serial command receiver on the LPC TXD1 line (TX1) that decodes UART command frames and issues single 8-bit Wishbone master cycles onto the core bus. It is the inbound counterpart of the serial read-data path on RX1: the host writes channel and clock-generator registers over TX1, and read responses return over RX1. The block sits in the core beside the parallel bus master and drives the same slave strobe decode.

## Interface
- CLKS_PER_BIT, default 16: system clocks per UART bit; minimum 4.
- ACK_TIMEOUT, default 255: cycles stb_o may wait for ack_i before abort; only used with the timeout feature enabled.

- clk_i  in  1  system clock.
- rst_i  in  1  reset; asynchronous, active-low.
- rxd  in  1  UART input (8N1, idle high, LSB first); asynchronous to clk_i.
- stb_o  out  1  Wishbone strobe/cycle.
- we_o  out  1  Wishbone write enable.
- adr_o  out  8  Wishbone address; [7:4] selects the slave, [3:0] selects the register.
- dat_o  out  8  Wishbone write data.
- ack_i  in  1  Wishbone acknowledge from the slave mux.
- busy_o  out  1  high while stb_o is high.
- frame_err_o  out  1  one-cycle pulse on a bad stop bit.
- overrun_o  out  1  one-cycle pulse when a byte is dropped.
- timeout_o  out  1  one-cycle pulse when a cycle is aborted (tied 0 when the timeout feature is compiled out).

## Operation
- rxd passes through a 2-FF synchronizer. All rxd references below mean the synchronized value.
- Receiver FSM:
  - IDLE: a high-to-low transition moves to START.
  - START: wait CLKS_PER_BIT/2 cycles, then sample. If the sample is low, go to DATA; if high, it was a false start and the FSM returns to IDLE.
  - DATA: sample every CLKS_PER_BIT cycles, 8 bits, LSB first.
  - STOP: sample after CLKS_PER_BIT cycles. If high, the byte is valid. If low, pulse frame_err_o, discard the byte, and return the parser to HDR.
  - The FSM returns to IDLE after STOP.
- Parser FSM (state advances on each valid byte):
  - HDR: 0x57 ('W') goes to WADR; 0x52 ('R') goes to RADR; any other byte is silently discarded and the parser stays in HDR.
  - WADR: latch adr_o, go to WDAT.
  - WDAT: latch dat_o, set we_o=1, go to BUS.
  - RADR: latch adr_o, set we_o=0, go to BUS.
  - BUS: stb_o=1 until ack_i (or timeout), then return to HDR.
- The receiver keeps running during BUS. A valid byte completing while in BUS is dropped and overrun_o pulses. The parser state is unchanged.
- Read data is not captured here; the RX1 read path snoops the bus.
- adr_o, dat_o and we_o hold their last values between cycles.

## Timing
- Reset values: stb_o=0, we_o=0, adr_o=0x00, dat_o=0x00, busy_o=0, all pulses 0. Both FSMs reset to IDLE/HDR.
- Byte valid: asserted 1 cycle after the stop-bit sample.
- stb_o: rises 1 cycle after the final frame byte is valid. adr_o, dat_o and we_o are stable from that edge until stb_o falls.
- Termination: when ack_i is sampled high on a clock edge with stb_o high, stb_o is low on the next cycle. The parser is in HDR and can accept a byte on that same next cycle.
- ack_i while stb_o is low is ignored.
- A valid byte and ack_i on the same cycle: the cycle completes and the byte is dropped with overrun_o.
- Reset asserted mid-byte or mid-cycle: stb_o drops immediately (asynchronously), the partial frame is lost, and the receiver waits for a fresh falling edge after release.
- UART bit timing tolerance: ±2% clock mismatch.

## Configuration
- UART_BUS_TIMEOUT_EN:
  - Defined: a counter runs while stb_o is high. When it reaches ACK_TIMEOUT cycles with no ack_i, stb_o drops on the next cycle, timeout_o pulses once, and the parser returns to HDR. An ack on the terminal cycle wins over the timeout.
  - Undefined: the counter is not built, stb_o waits for ack_i indefinitely, and timeout_o is constant 0.

## Test plan
All scenarios use CLKS_PER_BIT=4.
- Write: send 0x57,0x21,0xA5 with ack_i after 2 cycles -> one stb_o cycle with we_o=1, adr_o=0x21, dat_o=0xA5; stb_o falls 1 cycle after ack_i.
- Read: send 0x52,0x93 -> stb_o with we_o=0, adr_o=0x93; stb_o held until ack_i.
- Noise: a 1-cycle low glitch on rxd, then header 0x00 followed by a valid 'W' frame -> no strobe from the glitch or the 0x00; one correct write from the 'W' frame.
- Framing: 0x57 sent with stop bit=0 -> frame_err_o pulses; a following 0x21,0xA5 alone produces no strobe.
- Overrun: hold ack_i low while sending 0x52 during an outstanding cycle -> overrun_o pulses; the pending cycle still completes on ack_i.
- Timeout (with UART_BUS_TIMEOUT_EN, ACK_TIMEOUT=8): no ack_i -> stb_o high exactly 8 cycles, timeout_o pulses once; reset mid-cycle drops stb_o asynchronously.
